// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared encodings for the multi-cycle MIPS-subset control path:
//   FSM state encoding, opcode and funct values, ALUControl codes,
//   ALUSrcB select codes and the 2-bit ALUOp handed to the ALU decoder.
//   Optional feature macro: MC_CTRL_ADDI_EN (addi support). The
//   ADDIEX/ADDIWB encodings always exist here, but the FSM only uses them
//   when the macro is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// mc_alu_decoder
//   Turns the FSM's 2-bit ALUOp plus the instruction funct field into the
//   3-bit ALUControl code. Unrecognised funct values fall back to add.
//   Ports:
//     alu_op      in  2  00 add, 01 sub, 10 decode funct, 11 add
//     funct       in  6  Instr[5:0]
//     alu_control out 3  ALU operation code
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Only R-type execution consults funct; every other ALUOp is fixed.
    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUC_ADD;
                    FUNCT_SUB: alu_control = ALUC_SUB;
                    FUNCT_AND: alu_control = ALUC_AND;
                    FUNCT_OR:  alu_control = ALUC_OR;
                    FUNCT_SLT: alu_control = ALUC_SLT;
                    default:   alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Moore controller for a multi-cycle MIPS-subset datapath (lw, sw,
//   R-type add/sub/and/or/slt, beq, optional addi). Outputs are decoded
//   from the current state only; the next state depends on state and op.
//   Optional feature macro: MC_CTRL_ADDI_EN enables the addi sequence
//   (ADDIEX -> ADDIWB). Without it op 001000 behaves as an unknown opcode.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     op, funct            opcode / funct fields from the IR
//     RegWrite, RegDst, MemtoReg        register-file write controls
//     ALUSrcA, ALUSrcB, ALUControl      ALU operand / operation selects
//     PCSrc, Branch, PCWrite            PC update controls
//     IorD, MemWrite, IRWrite           memory / IR controls
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       PCSrc,
    output logic       Branch,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg
);

    state_t     state;
    logic [1:0] alu_op;
    logic       reg_write_raw;
    logic       branch_raw;
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;

    // State register. Any encoding without a case item (including the addi
    // states when that feature is compiled out) returns to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
`ifdef MC_CTRL_ADDI_EN
                        OP_ADDI:      state <= S_ADDIEX;
`else
                        OP_ADDI:      state <= S_FETCH;
`endif
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state <= S_MEMWB;
                S_MEMWB:   state <= S_FETCH;
                S_MEMWR:   state <= S_FETCH;
                S_EXECUTE: state <= S_ALUWB;
                S_ALUWB:   state <= S_FETCH;
                S_BRANCH:  state <= S_FETCH;
`ifdef MC_CTRL_ADDI_EN
                S_ADDIEX:  state <= S_ADDIWB;
                S_ADDIWB:  state <= S_FETCH;
`endif
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Per-state output decode; anything not set for a state stays 0 and
    // the ALU defaults to add.
    always_comb begin
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        alu_op        = ALUOP_ADD;
        PCSrc         = 1'b0;
        branch_raw    = 1'b0;
        pc_write_raw  = 1'b0;
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            S_DECODE: ALUSrcB = SRCB_IMMSH2;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = 1'b1;
                branch_raw = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: reg_write_raw = 1'b1;
`endif
            default: ;
        endcase
    end

    // Reset suppresses every architectural write immediately, so an
    // instruction interrupted by reset leaves no trace.
    assign RegWrite = reg_write_raw & ~rst;
    assign Branch   = branch_raw    & ~rst;
    assign PCWrite  = pc_write_raw  & ~rst;
    assign MemWrite = mem_write_raw & ~rst;
    assign IRWrite  = ir_write_raw  & ~rst;

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
//   Self-checking bench for mc_control_fsm. A per-instruction reference
//   model lists the expected control word for every cycle of an
//   instruction; directed instructions run first, then randomised ones,
//   some of them interrupted by reset. Honours MC_CTRL_ADDI_EN.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       RegWrite, ALUSrcA, PCSrc, Branch, PCWrite, IorD;
    logic       MemWrite, IRWrite, RegDst, MemtoReg;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;

    int checks = 0;
    int errors = 0;

    // Control word layout: RegWrite ALUSrcA ALUSrcB[1:0] ALUControl[2:0]
    // PCSrc Branch PCWrite IorD MemWrite IRWrite RegDst MemtoReg
    localparam logic [14:0] WE_MASK = 15'h406C;

    logic [14:0] outVec;
    logic [14:0] expSeq[$];

    assign outVec = {RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, Branch,
                     PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg};

    mc_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .Branch     (Branch),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ctl(input logic rw, input logic srca,
                                        input logic [1:0] srcb, input logic [2:0] aluc,
                                        input logic pcsrc, input logic br, input logic pcw,
                                        input logic iord, input logic mw, input logic irw,
                                        input logic rd, input logic mtr);
        return {rw, srca, srcb, aluc, pcsrc, br, pcw, iord, mw, irw, rd, mtr};
    endfunction

    function automatic logic [2:0] functOp(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Reference model: the full cycle-by-cycle control sequence of one
    // instruction, written straight from the per-instruction behaviour.
    task automatic buildModel(input logic [5:0] o, input logic [5:0] f);
        logic addiOn;
`ifdef MC_CTRL_ADDI_EN
        addiOn = 1'b1;
`else
        addiOn = 1'b0;
`endif
        expSeq.delete();
        expSeq.push_back(ctl(0, 0, 2'b01, 3'b010, 0, 0, 1, 0, 0, 1, 0, 0));
        expSeq.push_back(ctl(0, 0, 2'b11, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0));
        if (o == 6'b100011) begin
            expSeq.push_back(ctl(0, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0));
            expSeq.push_back(ctl(0, 0, 2'b00, 3'b010, 0, 0, 0, 1, 0, 0, 0, 0));
            expSeq.push_back(ctl(1, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1));
        end else if (o == 6'b101011) begin
            expSeq.push_back(ctl(0, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0));
            expSeq.push_back(ctl(0, 0, 2'b00, 3'b010, 0, 0, 0, 1, 1, 0, 0, 0));
        end else if (o == 6'b000000) begin
            expSeq.push_back(ctl(0, 1, 2'b00, functOp(f), 0, 0, 0, 0, 0, 0, 0, 0));
            expSeq.push_back(ctl(1, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0, 1, 0));
        end else if (o == 6'b000100) begin
            expSeq.push_back(ctl(0, 1, 2'b00, 3'b110, 1, 1, 0, 0, 0, 0, 0, 0));
        end else if (o == 6'b001000 && addiOn) begin
            expSeq.push_back(ctl(0, 1, 2'b10, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0));
            expSeq.push_back(ctl(1, 0, 2'b00, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic checkOutput(input logic [14:0] expected, input string tag);
        checks++;
        assert (outVec === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, outVec, expected);
        end
    endtask

    // Runs one instruction from its FETCH cycle. If abortAt names a cycle,
    // reset is raised in that cycle: writes must vanish at once and the
    // next instruction must start with a normal FETCH.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                                 input int abortAt, input string tag);
        buildModel(o, f);
        op    = o;
        funct = f;
        for (int i = 0; i < expSeq.size(); i++) begin
            if (i == abortAt) begin
                rst = 1'b1;
                #1;
                checkOutput(expSeq[i] & ~WE_MASK, $sformatf("%s_rst_c%0d", tag, i + 1));
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            #1;
            checkOutput(expSeq[i], $sformatf("%s_c%0d", tag, i + 1));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] rop;
        logic [5:0] rf;
        int         abortAt;
        logic [5:0] legalFunct[5];

        legalFunct[0] = 6'b100000;
        legalFunct[1] = 6'b100010;
        legalFunct[2] = 6'b100100;
        legalFunct[3] = 6'b100101;
        legalFunct[4] = 6'b101010;

        rst   = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;

        // Two reset cycles: FETCH selects visible, every write enable low.
        @(negedge clk);
        checkOutput(ctl(0, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0), "reset_c1");
        @(negedge clk);
        checkOutput(ctl(0, 0, 2'b01, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0), "reset_c2");
        rst = 1'b0;

        applyStimulus(6'b100011, 6'b000000, -1, "lw");
        applyStimulus(6'b101011, 6'b000000, -1, "sw");
        applyStimulus(6'b000000, 6'b101010, -1, "slt");
        applyStimulus(6'b000000, 6'b100010, -1, "sub");
        applyStimulus(6'b000000, 6'b100100, -1, "and");
        applyStimulus(6'b000000, 6'b100101, -1, "or");
        applyStimulus(6'b000000, 6'b111111, -1, "badfunct");
        applyStimulus(6'b000100, 6'b000000, -1, "beq");
        applyStimulus(6'b111111, 6'b000000, -1, "unknown");
        applyStimulus(6'b001000, 6'b000000, -1, "addi");
        applyStimulus(6'b001000, 6'b000000, 2, "addi_abort");
        applyStimulus(6'b100011, 6'b000000, 2, "lw_abort");
        applyStimulus(6'b101011, 6'b000000, 3, "sw_abort");
        applyStimulus(6'b100011, 6'b000000, -1, "lw_after_abort");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       rop = 6'b100011;
                1:       rop = 6'b101011;
                2:       rop = 6'b000000;
                3:       rop = 6'b000100;
                4:       rop = 6'b001000;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 3) == 0) rf = 6'($urandom_range(0, 63));
            else rf = legalFunct[$urandom_range(0, 4)];
            abortAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
            applyStimulus(rop, rf, abortAt, $sformatf("rnd%0d_op%b", n, rop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
